fifo_refill_ctrl: RTL and testbench
===================================

Name: fifo_refill_ctrl

Overview:
Upstream feeder for the 16-in/24-out sample FIFO on the 143 MHz domain. It watches the FIFO low and high watermarks and issues fixed-length burst read requests to the SDRAM read port. It forwards each returned 16-bit beat into the FIFO write port. Read addresses walk a circular region, so the sample stream repeats seamlessly.

Parameters:
WORD_W, 16, data beat width; matches the FIFO write word size
ADDR_W, 25, SDRAM word-address width
BURST_LEN, 8, beats per read request; power of two, 2..64
BASE_ADDR, 0, first word address of the streaming region
REGION_WORDS, 65536, region length in words; non-zero multiple of BURST_LEN

Ports:
clk143  in  1  system clock, 143 MHz
reset  in  1  synchronous, active-high reset
enable  in  1  permits new burst requests
buf_lw  in  1  FIFO low watermark (almost empty)
buf_hw  in  1  FIFO high watermark (almost full)
rd_req  out  1  burst read request to the SDRAM controller
rd_addr  out  ADDR_W  burst start address; valid while rd_req=1
rd_ack  in  1  controller accepts the request in this cycle
rd_valid  in  1  a returned data beat is valid
rd_data  in  WORD_W  returned data beat
fifo_we  out  1  FIFO write enable
fifo_din  out  WORD_W  FIFO write data
busy  out  1  a request or burst is outstanding (state != IDLE)
stray_err  out  1  sticky flag: rd_valid seen outside RECV

Behaviour:
- Reset values (synchronous, reset=1 at posedge clk143):
  - state=IDLE, rd_req=0, rd_addr=BASE_ADDR, fifo_we=0, fifo_din=0
  - busy=0, stray_err=0, fill_mode=0, beat count=0
- Hysteresis register fill_mode, updated every cycle:
  - buf_hw=1 clears it (hw wins).
  - Otherwise buf_lw=1 && enable=1 sets it.
  - Otherwise it holds.
- State IDLE:
  - Go to REQ when enable && !buf_hw && (fill_mode || buf_lw).
  - On entry to REQ, rd_req=1 in the next cycle.
- State REQ:
  - rd_req=1; rd_addr held stable.
  - Wait for rd_ack=1, then go to RECV the next cycle and drop rd_req.
  - Advance rd_addr by BURST_LEN. If the result is >= BASE_ADDR+REGION_WORDS, rd_addr=BASE_ADDR.
  - rd_ack while rd_req=0 is ignored.
- State RECV:
  - Count rd_valid beats, including beats arriving in the same cycle as rd_ack or later.
  - After beat BURST_LEN is counted:
    - Go to REQ directly if enable && !buf_hw && fill_mode.
    - Otherwise go to IDLE.
  - Bursts are never truncated: enable=0 or buf_hw=1 mid-burst still accepts all BURST_LEN beats.
- Data path, 1-cycle latency:
  - fifo_we <= rd_valid && (state==REQ-acked || state==RECV).
  - fifo_din <= rd_data.
  - Beat order is preserved. No beats are dropped or duplicated.
- rd_valid in IDLE, or in REQ before rd_ack: beat discarded, fifo_we stays 0, stray_err <= 1 until reset.
- busy=1 exactly when state is REQ or RECV.
- rd_addr width arithmetic is modulo 2^ADDR_W before the region-wrap compare. BASE_ADDR+REGION_WORDS must not exceed 2^ADDR_W.
- Reset mid-burst aborts immediately with no further fifo_we. The controller shares the same reset, so no stale beats are expected.

Test Plan:
- Basic refill: buf_lw=1, enable=1, ack after 3 cycles, 8 beats 0x0001..0x0008 -> rd_addr=0; 8 fifo_we pulses, each 1 cycle after its rd_valid, data 0x0001..0x0008 in order; next request at rd_addr=8.
- Hysteresis: pulse buf_lw=1 for 1 cycle, then both flags 0 -> back-to-back bursts at 0,8,16,…; raise buf_hw during the third burst -> that burst completes all 8 beats, state=IDLE, no fourth rd_req.
- Wrap: REGION_WORDS=16, BASE_ADDR=0x100 -> request addresses 0x100, 0x108, 0x100, 0x108.
- Enable drop: enable=0 while in RECV with 5 beats received -> remaining 3 beats written, then IDLE, busy=0, rd_req stays 0 while buf_lw=1.
- Stray beat: rd_valid=1 in IDLE -> fifo_we stays 0, stray_err=1 and stays set; reset clears it to 0.
- Reset mid-burst: reset after 4 of 8 beats -> next cycle fifo_we=0, rd_req=0, rd_addr=BASE_ADDR, busy=0.

Source files
------------

// File: rtl/fifo_refill_ctrl.sv
// Refill controller for the sample FIFO: issues fixed-length SDRAM burst reads
// over a circular address region and forwards returned beats into the FIFO.
module fifo_refill_ctrl #(
  parameter int WORD_W       = 16,
  parameter int ADDR_W       = 25,
  parameter int BURST_LEN    = 8,
  parameter int BASE_ADDR    = 0,
  parameter int REGION_WORDS = 65536
) (
  input  logic              clk143,
  input  logic              reset,
  input  logic              enable,
  input  logic              buf_lw,
  input  logic              buf_hw,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_ack,
  input  logic              rd_valid,
  input  logic [WORD_W-1:0] rd_data,
  output logic              fifo_we,
  output logic [WORD_W-1:0] fifo_din,
  output logic              busy,
  output logic              stray_err
);

  localparam int                CNT_W      = $clog2(BURST_LEN + 1);
  localparam logic [ADDR_W-1:0] BASE       = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   REGION_END = (ADDR_W+1)'(BASE_ADDR) + (ADDR_W+1)'(REGION_WORDS);
  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(BURST_LEN);
  localparam logic [CNT_W-1:0]  LAST_BEAT  = CNT_W'(BURST_LEN - 1);

  // Step wraps modulo 2^ADDR_W first, then folds back into the region.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] s;
    s = a + STEP;
    return ({1'b0, s} >= REGION_END) ? BASE : s;
  endfunction

  typedef enum logic [1:0] {IDLE, REQ, RECV} state_t;

  state_t           state;
  logic             fill_mode;
  logic [CNT_W-1:0] beat_cnt;

  logic acked, accept, stray, start, refill;

  assign acked  = (state == REQ) && rd_ack;
  assign accept = rd_valid && (acked || (state == RECV));
  assign stray  = rd_valid && ((state == IDLE) || ((state == REQ) && !rd_ack));
  assign start  = enable && !buf_hw && (fill_mode || buf_lw);
  assign refill = enable && !buf_hw && fill_mode;

  always_ff @(posedge clk143) begin
    if (reset) begin
      state     <= IDLE;
      rd_req    <= 1'b0;
      rd_addr   <= BASE;
      fifo_we   <= 1'b0;
      fifo_din  <= '0;
      busy      <= 1'b0;
      stray_err <= 1'b0;
      fill_mode <= 1'b0;
      beat_cnt  <= '0;
    end else begin
      fifo_we  <= accept;
      fifo_din <= rd_data;

      if (stray) stray_err <= 1'b1;

      // High watermark dominates so a full FIFO always stops refilling.
      if (buf_hw)                 fill_mode <= 1'b0;
      else if (buf_lw && enable)  fill_mode <= 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            state  <= REQ;
            rd_req <= 1'b1;
            busy   <= 1'b1;
          end
        end
        REQ: begin
          if (rd_ack) begin
            state    <= RECV;
            rd_req   <= 1'b0;
            rd_addr  <= next_addr(rd_addr);
            beat_cnt <= rd_valid ? CNT_W'(1) : '0;
          end
        end
        RECV: begin
          if (rd_valid) begin
            if (beat_cnt == LAST_BEAT) begin
              beat_cnt <= '0;
              if (refill) begin
                state  <= REQ;
                rd_req <= 1'b1;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              beat_cnt <= beat_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          state  <= IDLE;
          rd_req <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_refill_ctrl.sv
// Scoreboard bench for fifo_refill_ctrl: accepted beats are queued when driven
// and compared against FIFO writes; a second instance covers region wrap.
module tb_fifo_refill_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable, buf_lw, buf_hw, rd_ack, rd_valid;
  logic [15:0] rd_data;
  logic        rd_req, fifo_we, busy, stray_err;
  logic [24:0] rd_addr;
  logic [15:0] fifo_din;

  logic        w_enable, w_lw, w_hw, w_ack, w_valid;
  logic [15:0] w_data;
  logic        w_req, w_we, w_busy, w_stray;
  logic [24:0] w_addr;
  logic [15:0] w_din;

  int total = 0;
  int bad   = 0;
  int w_cnt = 0;
  logic [15:0] q[$];

  always #5 clk = ~clk;

  fifo_refill_ctrl dut (
    .clk143(clk), .reset(reset), .enable(enable), .buf_lw(buf_lw), .buf_hw(buf_hw),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_valid(rd_valid),
    .rd_data(rd_data), .fifo_we(fifo_we), .fifo_din(fifo_din), .busy(busy),
    .stray_err(stray_err)
  );

  fifo_refill_ctrl #(.BASE_ADDR(32'h100), .REGION_WORDS(16)) dut_w (
    .clk143(clk), .reset(reset), .enable(w_enable), .buf_lw(w_lw), .buf_hw(w_hw),
    .rd_req(w_req), .rd_addr(w_addr), .rd_ack(w_ack), .rd_valid(w_valid),
    .rd_data(w_data), .fifo_we(w_we), .fifo_din(w_din), .busy(w_busy),
    .stray_err(w_stray)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rd_ack = 0; rd_valid = 0; enable = 0; buf_lw = 0; buf_hw = 0;
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    while (!rd_req && n < 50) begin
      tick();
      n++;
    end
    chk("req_wait", rd_req, 1);
  endtask

  task automatic ack(input logic with_beat, input logic [15:0] d);
    rd_ack = 1;
    rd_valid = with_beat;
    rd_data = d;
    if (with_beat) q.push_back(d);
    tick();
    chk("ack_we", fifo_we, with_beat);
    chk("ack_req_drop", rd_req, 0);
    rd_ack = 0;
    rd_valid = 0;
  endtask

  task automatic beat(input logic [15:0] d);
    rd_valid = 1;
    rd_data = d;
    q.push_back(d);
    tick();
    chk("we_lat", fifo_we, 1);
    rd_valid = 0;
  endtask

  // Every FIFO write must match the oldest accepted beat.
  always @(negedge clk) begin
    if (fifo_we) begin
      if (q.size() == 0) chk("we_extra", 1, 0);
      else chk("din", fifo_din, q.pop_front());
    end
    if (w_we) w_cnt++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    w_enable = 0; w_lw = 0; w_hw = 0; w_ack = 0; w_valid = 0; w_data = 0;
    rd_data = 0;
    do_reset();
    reset = 1;
    tick();
    chk("rst_req", rd_req, 0);
    chk("rst_addr", rd_addr, 0);
    chk("rst_we", fifo_we, 0);
    chk("rst_din", fifo_din, 0);
    chk("rst_busy", busy, 0);
    chk("rst_stray", stray_err, 0);
    reset = 0;

    // Basic refill: ack after 3 cycles, first beat rides the ack cycle
    enable = 1; buf_lw = 1;
    tick();
    wait_req();
    chk("b_addr0", rd_addr, 0);
    chk("b_busy", busy, 1);
    repeat (3) begin
      tick();
      chk("b_req_hold", rd_req, 1);
      chk("b_addr_hold", rd_addr, 0);
    end
    ack(1, 16'h0001);
    for (int i = 2; i <= 8; i++) beat(16'(i));
    wait_req();
    chk("b_addr8", rd_addr, 8);
    buf_hw = 1; buf_lw = 0;
    ack(0, 16'h0);
    for (int i = 9; i <= 16; i++) beat(16'(i));
    chk("b_idle", busy, 0);
    tick();
    chk("b_noreq", rd_req, 0);

    // Hysteresis: one-cycle low-watermark pulse keeps bursts going
    do_reset();
    enable = 1; buf_lw = 1;
    tick();
    buf_lw = 0;
    for (int b = 0; b < 3; b++) begin
      wait_req();
      chk("h_addr", rd_addr, 32'(b * 8));
      ack(0, 16'h0);
      for (int i = 0; i < 8; i++) begin
        if (b == 2 && i == 3) buf_hw = 1;
        beat(16'(16'h100 + b * 16 + i));
      end
    end
    chk("h_idle", busy, 0);
    repeat (10) tick();
    chk("h_noreq", rd_req, 0);
    buf_hw = 0; enable = 0;

    // Enable drop mid-burst: remaining beats still written
    do_reset();
    enable = 1; buf_lw = 1;
    tick();
    wait_req();
    ack(0, 16'h0);
    for (int i = 0; i < 5; i++) beat(16'(16'h200 + i));
    enable = 0;
    for (int i = 5; i < 8; i++) beat(16'(16'h200 + i));
    chk("e_busy", busy, 0);
    chk("e_req", rd_req, 0);
    repeat (5) tick();
    chk("e_req_hold", rd_req, 0);
    chk("e_busy_hold", busy, 0);

    // Stray beat in IDLE, then in REQ before ack
    do_reset();
    rd_valid = 1; rd_data = 16'hdead;
    tick();
    rd_valid = 0;
    chk("s_we", fifo_we, 0);
    chk("s_flag", stray_err, 1);
    repeat (3) tick();
    chk("s_sticky", stray_err, 1);
    do_reset();
    chk("s_clear", stray_err, 0);
    enable = 1; buf_lw = 1;
    tick();
    wait_req();
    rd_valid = 1; rd_data = 16'hbeef;
    tick();
    rd_valid = 0;
    chk("s_req_we", fifo_we, 0);
    chk("s_req_flag", stray_err, 1);
    chk("s_req_still", rd_req, 1);

    // Reset mid-burst
    do_reset();
    enable = 1; buf_lw = 1;
    tick();
    wait_req();
    ack(0, 16'h0);
    for (int i = 0; i < 4; i++) beat(16'(16'h300 + i));
    reset = 1; rd_valid = 1; rd_data = 16'h3ff;
    tick();
    reset = 0; rd_valid = 0; enable = 0; buf_lw = 0;
    chk("r_we", fifo_we, 0);
    chk("r_req", rd_req, 0);
    chk("r_addr", rd_addr, 0);
    chk("r_busy", busy, 0);
    tick();
    chk("r_we2", fifo_we, 0);

    // Region wrap on the second instance
    w_enable = 1; w_lw = 1;
    tick();
    for (int b = 0; b < 4; b++) begin
      int n;
      n = 0;
      while (!w_req && n < 50) begin
        tick();
        n++;
      end
      chk("w_req", w_req, 1);
      chk("w_addr", w_addr, (b % 2 == 1) ? 32'h108 : 32'h100);
      if (b == 3) w_hw = 1;
      w_ack = 1;
      tick();
      w_ack = 0;
      for (int i = 0; i < 8; i++) begin
        w_valid = 1; w_data = 16'(b * 8 + i);
        tick();
      end
      w_valid = 0;
    end
    tick();
    chk("w_busy", w_busy, 0);
    chk("w_cnt", w_cnt, 32);
    chk("w_din", w_din, 16'd31);
    chk("w_stray", w_stray, 0);
    w_hw = 0; w_enable = 0; w_lw = 0;

    tick();
    chk("sb_left", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
